// File: rtl/cpu_ctrl_if.sv
// Handshake and datapath-control bundle between the multicycle controller
// and the simple_cpu datapath / instruction source.
interface cpu_ctrl_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 20,
    parameter int REG_BITS    = 2
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instruction;

    logic [REG_BITS-1:0]    rf_raddr_a;
    logic [REG_BITS-1:0]    rf_raddr_b;
    logic [REG_BITS-1:0]    rf_waddr;
    logic                   rf_wen;
    logic                   rf_wsel;

    logic                   alu_op;
    logic                   alu_b_sel;
    logic [DATA_WIDTH-1:0]  imm;

    logic                   mem_ren;
    logic                   mem_wen;

    logic                   done;
    logic                   illegal;

    // Controller side: takes instructions in, drives the datapath controls.
    modport master (
        input  instr_valid,
        input  instruction,
        output instr_ready,
        output rf_raddr_a,
        output rf_raddr_b,
        output rf_waddr,
        output rf_wen,
        output rf_wsel,
        output alu_op,
        output alu_b_sel,
        output imm,
        output mem_ren,
        output mem_wen,
        output done,
        output illegal
    );

    // Instruction source / datapath side.
    modport slave (
        output instr_valid,
        output instruction,
        input  instr_ready,
        input  rf_raddr_a,
        input  rf_raddr_b,
        input  rf_waddr,
        input  rf_wen,
        input  rf_wsel,
        input  alu_op,
        input  alu_b_sel,
        input  imm,
        input  mem_ren,
        input  mem_wen,
        input  done,
        input  illegal
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit for simple_cpu. One instruction is accepted per
// valid/ready handshake into an internal IR, then sequenced through
// DECODE/EXEC/MEM/WB (or ERR for rejected encodings). All datapath controls
// are Moore outputs decoded from the state and the IR only, so an async
// reset drops every strobe immediately. Truncation of the ALU result to the
// data-memory address width is done in the datapath, not here.
module cpu_ctrl_fsm #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 20,
    parameter int REG_BITS    = 2
) (
    input  logic       clk,
    input  logic       rst,
    cpu_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [1:0] TYPE_ALU   = 2'b01;
    localparam logic [1:0] TYPE_LOAD  = 2'b10;
    localparam logic [1:0] TYPE_STORE = 2'b11;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;

    logic [1:0] ir_type;
    logic [1:0] ir_x1;
    logic [1:0] ir_x2;
    logic [1:0] ir_x3;
    logic [7:0] ir_imm;
    logic [3:0] ir_opcode;
    logic       is_alu;
    logic       is_load;
    logic       is_store;
    logic       is_illegal;

    assign ir_type   = ir_q[19:18];
    assign ir_x1     = ir_q[17:16];
    assign ir_x2     = ir_q[15:14];
    assign ir_x3     = ir_q[13:12];
    assign ir_imm    = ir_q[11:4];
    assign ir_opcode = ir_q[3:0];

    assign is_alu     = (ir_type == TYPE_ALU);
    assign is_load    = (ir_type == TYPE_LOAD);
    assign is_store   = (ir_type == TYPE_STORE);
    // Type 00 is never valid; ALU opcodes above SUB are reserved.
    assign is_illegal = (ir_type == 2'b00) || (is_alu && (ir_opcode[3:1] != 3'b000));

    // State and instruction register, cleared immediately by the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state sequencing; the IR only loads on an accepted handshake.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instruction;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = is_illegal ? ERR : EXEC;
            end
            EXEC: begin
                state_d = is_alu ? WB : MEM;
            end
            MEM: begin
                state_d = is_load ? WB : IDLE;
            end
            WB: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode: IR-derived fields are held from DECODE to retire, strobes only in their states.
    always_comb begin
        bus.instr_ready = (state_q == IDLE);
        bus.rf_raddr_a  = '0;
        bus.rf_raddr_b  = '0;
        bus.rf_waddr    = '0;
        bus.rf_wen      = 1'b0;
        bus.rf_wsel     = 1'b0;
        bus.alu_op      = 1'b0;
        bus.alu_b_sel   = 1'b0;
        bus.imm         = '0;
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;

        if (state_q != IDLE) begin
            bus.rf_raddr_a = REG_BITS'(ir_x2);
            bus.rf_raddr_b = is_store ? REG_BITS'(ir_x1) : REG_BITS'(ir_x3);
            bus.rf_waddr   = REG_BITS'(ir_x1);
            bus.imm        = DATA_WIDTH'(ir_imm);
            bus.alu_op     = is_alu & ir_q[0];
            bus.alu_b_sel  = is_load | is_store;
        end

        case (state_q)
            MEM: begin
                if (is_load) begin
                    bus.mem_ren = 1'b1;
                end else begin
                    bus.mem_wen = 1'b1;
                    bus.done    = 1'b1;
                end
            end
            WB: begin
                bus.rf_wen  = 1'b1;
                bus.rf_wsel = is_load;
                bus.done    = 1'b1;
            end
            ERR: begin
                bus.done    = 1'b1;
                bus.illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed, table-driven bench for cpu_ctrl_fsm with a few hand-written
// multi-cycle sequences (load latency, async reset mid-store, back-to-back issue).
module tb_cpu_ctrl_fsm;

    typedef struct packed {
        logic       ready;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] wa;
        logic       wen;
        logic       wsel;
        logic       aop;
        logic       bsel;
        logic [7:0] imm;
        logic       mren;
        logic       mwen;
        logic       done;
        logic       ill;
    } outs_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [19:0] instr;
        outs_t       exp;
    } vec_t;

    localparam logic [19:0] I_ADD   = 20'b01000111000000000000;
    localparam logic [19:0] I_SUB   = 20'b01110010000000000001;
    localparam logic [19:0] I_STORE = 20'b11011000000011110000;
    localparam logic [19:0] I_LOAD  = 20'b10111000000011110000;
    localparam logic [19:0] I_ILL0  = 20'h00000;
    localparam logic [19:0] I_ILL2  = 20'b01000111000000000010;
    localparam logic [19:0] I_ILL14 = 20'b01100100000000011110;
    localparam logic [19:0] I_JUNK  = 20'hFFFFF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    cpu_ctrl_if bus ();

    cpu_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t o(logic ready, logic [1:0] ra, logic [1:0] rb, logic [1:0] wa,
                                logic wen, logic wsel, logic aop, logic bsel, logic [7:0] imm,
                                logic mren, logic mwen, logic done, logic ill);
        outs_t r;
        r.ready = ready; r.ra = ra; r.rb = rb; r.wa = wa;
        r.wen = wen; r.wsel = wsel; r.aop = aop; r.bsel = bsel; r.imm = imm;
        r.mren = mren; r.mwen = mwen; r.done = done; r.ill = ill;
        return r;
    endfunction

    function automatic outs_t sample();
        outs_t r;
        r.ready = bus.instr_ready; r.ra = bus.rf_raddr_a; r.rb = bus.rf_raddr_b;
        r.wa = bus.rf_waddr; r.wen = bus.rf_wen; r.wsel = bus.rf_wsel;
        r.aop = bus.alu_op; r.bsel = bus.alu_b_sel; r.imm = bus.imm;
        r.mren = bus.mem_ren; r.mwen = bus.mem_wen; r.done = bus.done; r.ill = bus.illegal;
        return r;
    endfunction

    function automatic void add(string name, logic r, logic v, logic [19:0] i, outs_t e);
        vec_t t;
        t.name = name; t.rst = r; t.valid = v; t.instr = i; t.exp = e;
        vecs.push_back(t);
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [19:0] i);
        rst             = r;
        bus.instr_valid = v;
        bus.instruction = i;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        outs_t idle0;
        int    cycles;
        int    accepts;
        int    dones;

        n_checks = 0;
        n_fail   = 0;
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;

        idle0 = o(1, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0);

        add("reset0", 0, 0, 0, idle0);
        add("reset1", 0, 0, 0, idle0);
        add("reset2", 0, 0, 0, idle0);

        add("add_accept", 1, 1, I_ADD, idle0);
        add("add_decode", 1, 0, 0, o(0, 1, 3, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0));
        add("add_exec",   1, 0, 0, o(0, 1, 3, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0));
        add("add_wb",     1, 0, 0, o(0, 1, 3, 0, 1, 0, 0, 0, 8'd0, 0, 0, 1, 0));
        add("add_idle",   1, 0, 0, idle0);

        add("sub_accept", 1, 1, I_SUB, idle0);
        add("sub_decode", 1, 1, I_JUNK, o(0, 0, 2, 3, 0, 0, 1, 0, 8'd0, 0, 0, 0, 0));
        add("sub_exec",   1, 1, I_JUNK, o(0, 0, 2, 3, 0, 0, 1, 0, 8'd0, 0, 0, 0, 0));
        add("sub_wb",     1, 1, I_JUNK, o(0, 0, 2, 3, 1, 0, 1, 0, 8'd0, 0, 0, 1, 0));
        add("sub_idle",   1, 0, 0, idle0);

        add("st_accept",  1, 1, I_STORE, idle0);
        add("st_decode",  1, 0, 0, o(0, 2, 1, 1, 0, 0, 0, 1, 8'd15, 0, 0, 0, 0));
        add("st_exec",    1, 0, 0, o(0, 2, 1, 1, 0, 0, 0, 1, 8'd15, 0, 0, 0, 0));
        add("st_mem",     1, 0, 0, o(0, 2, 1, 1, 0, 0, 0, 1, 8'd15, 0, 1, 1, 0));
        add("st_idle",    1, 0, 0, idle0);

        add("ld_accept",  1, 1, I_LOAD, idle0);
        add("ld_decode",  1, 0, 0, o(0, 2, 0, 3, 0, 0, 0, 1, 8'd15, 0, 0, 0, 0));
        add("ld_exec",    1, 0, 0, o(0, 2, 0, 3, 0, 0, 0, 1, 8'd15, 0, 0, 0, 0));
        add("ld_mem",     1, 0, 0, o(0, 2, 0, 3, 0, 0, 0, 1, 8'd15, 1, 0, 0, 0));
        add("ld_wb",      1, 0, 0, o(0, 2, 0, 3, 1, 1, 0, 1, 8'd15, 0, 0, 1, 0));
        add("ld_idle",    1, 0, 0, idle0);

        add("ill0_accept", 1, 1, I_ILL0, idle0);
        add("ill0_decode", 1, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0));
        add("ill0_err",    1, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 1, 1));
        add("ill0_idle",   1, 0, 0, idle0);

        add("ill2_accept", 1, 1, I_ILL2, idle0);
        add("ill2_decode", 1, 0, 0, o(0, 1, 3, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0));
        add("ill2_err",    1, 0, 0, o(0, 1, 3, 0, 0, 0, 0, 0, 8'd0, 0, 0, 1, 1));
        add("ill2_idle",   1, 0, 0, idle0);

        add("ill14_accept", 1, 1, I_ILL14, idle0);
        add("ill14_decode", 1, 0, 0, o(0, 1, 0, 2, 0, 0, 0, 0, 8'd1, 0, 0, 0, 0));
        add("ill14_err",    1, 0, 0, o(0, 1, 0, 2, 0, 0, 0, 0, 8'd1, 0, 0, 1, 1));
        add("ill14_idle",   1, 0, 0, idle0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].instr);
            #1;
            checkOutput(vecs[i].name, vecs[i].exp);
            tick();
        end

        // LOAD completion latency measured with a bounded wait.
        applyStimulus(1, 1, I_LOAD);
        tick();
        applyStimulus(1, 0, 0);
        cycles = 1;
        while (!bus.done && cycles < 10) begin
            tick();
            cycles++;
        end
        checkValue("load_latency", cycles, 4);
        checkValue("load_wsel_at_done", int'(bus.rf_wsel), 1);
        tick();
        checkValue("load_ready_after_done", int'(bus.instr_ready), 1);

        // Async reset in the middle of a STORE's MEM cycle.
        applyStimulus(1, 1, I_STORE);
        tick();
        applyStimulus(1, 0, 0);
        tick();
        tick();
        checkValue("rst_mid_mem_wen_before", int'(bus.mem_wen), 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_mem_async", idle0);
        tick();
        applyStimulus(1, 0, 0);
        #1;
        checkOutput("rst_release_idle", idle0);
        tick();

        // instr_valid held high: accepts only when ready, one instruction per 4 cycles.
        applyStimulus(1, 1, I_ADD);
        accepts = 0;
        dones   = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.instr_valid && bus.instr_ready) accepts++;
            if (bus.done) dones++;
            tick();
        end
        applyStimulus(1, 0, 0);
        checkValue("held_valid_accepts", accepts, 3);
        checkValue("held_valid_dones", dones, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
